// File: rtl/cam_capture.sv
// Camera sensor byte-stream capture: assembles two-byte pixels, converts the format,
// optionally decimates by 2 and writes the stored pixels into a frame buffer.
module cam_capture #(
    parameter int AW    = 15,
    parameter int DW    = 8,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int DEC   = 1
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          capture_en,
    input  logic [1:0]    fmt,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          busy,
    output logic          frame_done,
    output logic [1:0]    frame_err
);
    localparam int SENS_W = IMG_W * DEC;
    localparam int SENS_H = IMG_H * DEC;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int CW     = $clog2(SENS_W + 1);
    localparam int LW     = $clog2(SENS_H + 1);
    localparam int PW     = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, DONE} state_t;

    state_t        state_reg;
    logic [1:0]    fmt_reg;
    logic          phase_reg;
    logic          href_reg;
    logic [7:0]    byte0_reg;
    logic [CW-1:0] col_reg;
    logic [LW-1:0] line_reg;
    logic          col_odd_reg;
    logic          line_odd_reg;
    logic [PW-1:0] pix_cnt_reg;
    logic          ovf_reg;

    logic [CW-1:0] st_col;
    logic [LW-1:0] st_line;
    logic          dec_ok;
    logic          in_range;
    logic [AW-1:0] addr_next;
    logic [DW-1:0] pix_next;

    // Column/line counters saturate at the sensor size; separate parity bits keep
    // the decimation test exact even for over-long lines and frames.
    assign st_col    = col_reg >> (DEC - 1);
    assign st_line   = line_reg >> (DEC - 1);
    assign dec_ok    = (DEC == 1) || (!col_odd_reg && !line_odd_reg);
    assign in_range  = (col_reg < CW'(SENS_W)) && (line_reg < LW'(SENS_H));
    assign addr_next = AW'(st_line) * AW'(IMG_W) + AW'(st_col);

    generate
        if (DW == 12) begin : g_dw12
            always_comb begin
                case (fmt_reg)
                    2'b01:   pix_next = {byte0_reg[7:4], byte0_reg[2:0], px_data[7], px_data[4:1]};
                    2'b10:   pix_next = {4'b0000, byte0_reg};
                    default: pix_next = {4'b0000, byte0_reg[7:5], byte0_reg[2:0], px_data[4:3]};
                endcase
            end
        end else begin : g_dw8
            always_comb begin
                case (fmt_reg)
                    2'b10:   pix_next = byte0_reg;
                    default: pix_next = {byte0_reg[7:5], byte0_reg[2:0], px_data[4:3]};
                endcase
            end
        end
    endgenerate

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            fmt_reg      <= 2'b00;
            phase_reg    <= 1'b0;
            href_reg     <= 1'b0;
            byte0_reg    <= 8'h00;
            col_reg      <= '0;
            line_reg     <= '0;
            col_odd_reg  <= 1'b0;
            line_odd_reg <= 1'b0;
            pix_cnt_reg  <= '0;
            ovf_reg      <= 1'b0;
            mem_px_addr  <= '0;
            mem_px_data  <= '0;
            px_wr        <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 2'b00;
        end else begin
            px_wr      <= 1'b0;
            frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (capture_en && vsync) begin
                        state_reg <= SYNC;
                        busy      <= 1'b1;
                    end
                end
                SYNC: begin
                    if (!vsync) begin
                        state_reg    <= CAPTURE;
                        fmt_reg      <= fmt;
                        phase_reg    <= 1'b0;
                        href_reg     <= 1'b0;
                        col_reg      <= '0;
                        line_reg     <= '0;
                        col_odd_reg  <= 1'b0;
                        line_odd_reg <= 1'b0;
                        pix_cnt_reg  <= '0;
                        ovf_reg      <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (vsync) begin
                        // A pixel completing on the vsync edge is dropped here.
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        phase_reg <= 1'b0;
                    end else begin
                        href_reg <= href;
                        if (href) begin
                            phase_reg <= !phase_reg;
                            if (!phase_reg) begin
                                byte0_reg <= px_data;
                            end else begin
                                if (col_reg < CW'(SENS_W))
                                    col_reg <= col_reg + 1'b1;
                                col_odd_reg <= !col_odd_reg;
                                if (dec_ok) begin
                                    if (in_range) begin
                                        px_wr       <= 1'b1;
                                        mem_px_addr <= addr_next;
                                        mem_px_data <= pix_next;
                                        pix_cnt_reg <= pix_cnt_reg + 1'b1;
                                    end else begin
                                        ovf_reg <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            phase_reg <= 1'b0;
                            if (href_reg) begin
                                col_reg      <= '0;
                                col_odd_reg  <= 1'b0;
                                line_odd_reg <= !line_odd_reg;
                                if (line_reg < LW'(SENS_H))
                                    line_reg <= line_reg + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    frame_err  <= {ovf_reg, pix_cnt_reg < PW'(NPIX)};
                    busy       <= capture_en;
                    state_reg  <= capture_en ? SYNC : IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
